// File: rtl/sublime_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sublime_pkg : shared I2S framing constants and sample masking helper. Rev 1.0
// ---------------------------------------------------------------------------
package sublime_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_CNT_W = 6;

  // Keep the DATA_BITS most significant bits and clear the rest of the slot.
  function automatic logic [SLOT_BITS-1:0] i2s_mask(input logic [SLOT_BITS-1:0] sample,
                                                    input int data_bits);
    return sample & ({SLOT_BITS{1'b1}} << (SLOT_BITS - data_bits));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sublime_i2s_bclk_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sublime_i2s_bclk_gen : bit clock divider with one-cycle rise/fall enables. Rev 1.0
// ---------------------------------------------------------------------------
module sublime_i2s_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  // rise/fall flag the cycle whose edge changes bclk, so consumers update in step with it.
  assign wrap = enable && (div_cnt == DIV_LAST);
  assign rise = wrap && !bclk;
  assign fall = wrap && bclk;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sublime_i2s_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sublime_i2s_tx : stereo 32-bit slot I2S master transmitter. Rev 1.0
// ---------------------------------------------------------------------------
module sublime_i2s_tx
  import sublime_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int DATA_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] left_sample,
  input  logic [31:0] right_sample,
  output logic        sample_strobe,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  logic                  bclk_rise;
  logic                  bclk_fall;
  logic [SLOT_CNT_W-1:0] slot;
  logic [SLOT_CNT_W-1:0] next_slot;
  logic [SLOT_CNT_W-1:0] lead_slot;
  logic [FRAME_BITS-1:0] shift_reg;

  sublime_i2s_bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .bclk  (i2s_bclk),
    .rise  (bclk_rise),
    .fall  (bclk_fall)
  );

  // Word select runs one slot ahead of the data for the I2S one-bit lead.
  assign next_slot = slot + SLOT_CNT_W'(1);
  assign lead_slot = next_slot + SLOT_CNT_W'(1);
  assign i2s_sdata = shift_reg[FRAME_BITS-1];

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      slot          <= '1;
      shift_reg     <= '0;
      i2s_lrclk     <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (bclk_fall) begin
        slot      <= next_slot;
        i2s_lrclk <= lead_slot[SLOT_CNT_W-1];
        if (next_slot == '0) begin
          shift_reg     <= {i2s_mask(left_sample, DATA_BITS), i2s_mask(right_sample, DATA_BITS)};
          sample_strobe <= 1'b1;
        end else begin
          shift_reg <= shift_reg << 1;
        end
      end
    end
  end

  a_edges_exclusive: assert property (@(posedge clk) !(bclk_rise && bclk_fall));

endmodule
`default_nettype wire

// File: tb/tb_sublime_i2s_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sublime_i2s_tx : directed self-checking bench for sublime_i2s_tx. Rev 1.0
// ---------------------------------------------------------------------------
module tb_sublime_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] left_s = '0;
  logic [31:0] right_s = '0;
  wire  [2:0]  st_v;
  wire  [2:0]  bclk_v;
  wire  [2:0]  lr_v;
  wire  [2:0]  sd_v;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // idx 0: CLK_DIV=2/32 bits, idx 1: CLK_DIV=2/24 bits, idx 2: CLK_DIV=1/32 bits
  sublime_i2s_tx #(.CLK_DIV(2), .DATA_BITS(32)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .left_sample(left_s), .right_sample(right_s),
    .sample_strobe(st_v[0]), .i2s_bclk(bclk_v[0]), .i2s_lrclk(lr_v[0]), .i2s_sdata(sd_v[0]));
  sublime_i2s_tx #(.CLK_DIV(2), .DATA_BITS(24)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .left_sample(left_s), .right_sample(right_s),
    .sample_strobe(st_v[1]), .i2s_bclk(bclk_v[1]), .i2s_lrclk(lr_v[1]), .i2s_sdata(sd_v[1]));
  sublime_i2s_tx #(.CLK_DIV(1), .DATA_BITS(32)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .left_sample(left_s), .right_sample(right_s),
    .sample_strobe(st_v[2]), .i2s_bclk(bclk_v[2]), .i2s_lrclk(lr_v[2]), .i2s_sdata(sd_v[2]));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (st_v[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples sdata/lrclk on each bclk rising edge, 64 bits, MSB first.
  task automatic collect(input int idx, output logic [63:0] data, output logic [63:0] lr,
                         output bit ok);
    logic prev;
    int   got;
    prev = bclk_v[idx];
    got  = 0;
    data = '0;
    lr   = '0;
    for (int i = 0; i < 2000 && got < 64; i++) begin
      step();
      if (bclk_v[idx] && !prev) begin
        data = {data[62:0], sd_v[idx]};
        lr   = {lr[62:0], lr_v[idx]};
        got++;
      end
      prev = bclk_v[idx];
    end
    ok = (got == 64);
  endtask

  task automatic test_reset();
    int   rise_at, fall_at, s1, s2, nstrobe;
    logic prev;
    rise_at = -1; fall_at = -1; s1 = -1; s2 = -1; nstrobe = 0; prev = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    left_s = 32'hFFFF_FFFF;
    right_s = 32'hFFFF_FFFF;
    repeat (3) step();
    checks++;
    if ({st_v, bclk_v, lr_v, sd_v} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=000", {st_v, bclk_v, lr_v, sd_v});
    end
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (bclk_v[0] && !prev && rise_at < 0) rise_at = n;
      if (!bclk_v[0] && prev && fall_at < 0) fall_at = n;
      prev = bclk_v[0];
      if (st_v[0]) begin
        nstrobe++;
        if (s1 < 0) s1 = n;
        else if (s2 < 0) s2 = n;
      end
    end
    checks++;
    if (rise_at !== 2) begin failures++; $display("FAIL first_rise actual=%0d required=2", rise_at); end
    checks++;
    if (fall_at !== 4) begin failures++; $display("FAIL first_fall actual=%0d required=4", fall_at); end
    checks++;
    if (s1 !== 4) begin failures++; $display("FAIL first_strobe actual=%0d required=4", s1); end
    checks++;
    if (s2 !== 260) begin failures++; $display("FAIL second_strobe actual=%0d required=260", s2); end
    checks++;
    if (nstrobe !== 2) begin failures++; $display("FAIL strobe_cycles actual=%0d required=2", nstrobe); end
  endtask

  task automatic test_serial_frame();
    logic [63:0] d, lr;
    bit          ok;
    left_s = 32'hA5A5_0F0F;
    right_s = 32'h8000_0001;
    do_reset();
    wait_strobe(0, 300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL serial_strobe_timeout actual=0 required=1"); end
    collect(0, d, lr, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL serial_collect_timeout actual=0 required=1"); end
    checks++;
    if (d[63:32] !== 32'hA5A5_0F0F) begin
      failures++; $display("FAIL serial_left actual=%h required=a5a50f0f", d[63:32]);
    end
    checks++;
    if (d[31:0] !== 32'h8000_0001) begin
      failures++; $display("FAIL serial_right actual=%h required=80000001", d[31:0]);
    end
    checks++;
    if (lr !== 64'h0000_0001_FFFF_FFFE) begin
      failures++; $display("FAIL serial_lrclk actual=%h required=00000001fffffffe", lr);
    end
  endtask

  task automatic test_masking();
    logic [63:0] d, lr;
    bit          ok;
    left_s = 32'hFFFF_FFFF;
    right_s = 32'hFFFF_FFFF;
    do_reset();
    wait_strobe(1, 300, ok);
    collect(1, d, lr, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mask_collect_timeout actual=0 required=1"); end
    checks++;
    if (d !== 64'hFFFF_FF00_FFFF_FF00) begin
      failures++; $display("FAIL mask_frame actual=%h required=ffffff00ffffff00", d);
    end
  endtask

  task automatic test_capture_isolation();
    logic [63:0] d, lr;
    bit          ok;
    left_s = 32'h1234_5678;
    right_s = 32'h0F0F_0F0F;
    do_reset();
    wait_strobe(0, 300, ok);
    step();
    left_s = 32'hDEAD_BEEF;
    collect(0, d, lr, ok);
    checks++;
    if (d !== {32'h1234_5678, 32'h0F0F_0F0F}) begin
      failures++; $display("FAIL isolation_current actual=%h required=123456780f0f0f0f", d);
    end
    wait_strobe(0, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL isolation_strobe_timeout actual=0 required=1"); end
    collect(0, d, lr, ok);
    checks++;
    if (d !== {32'hDEAD_BEEF, 32'h0F0F_0F0F}) begin
      failures++; $display("FAIL isolation_next actual=%h required=deadbeef0f0f0f0f", d);
    end
  endtask

  task automatic test_enable_midframe();
    logic [63:0] d, lr;
    bit          ok;
    logic        prev;
    int          falls, nstrobe, busy, n;
    left_s = 32'h0000_0000;
    right_s = 32'hFFFF_FFFF;
    do_reset();
    wait_strobe(0, 300, ok);
    prev = bclk_v[0];
    falls = 0;
    for (int i = 0; i < 400 && falls < 40; i++) begin
      step();
      if (!bclk_v[0] && prev) falls++;
      prev = bclk_v[0];
    end
    checks++;
    if ({lr_v[0], sd_v[0]} !== 2'b11) begin
      failures++; $display("FAIL slot40_state actual=%b required=11", {lr_v[0], sd_v[0]});
    end
    enable = 1'b0;
    step();
    checks++;
    if ({bclk_v[0], lr_v[0], sd_v[0], st_v[0]} !== 4'b0000) begin
      failures++;
      $display("FAIL disable_outputs actual=%b required=0000", {bclk_v[0], lr_v[0], sd_v[0], st_v[0]});
    end
    nstrobe = 0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (st_v[0]) nstrobe++;
      if (bclk_v[0] || lr_v[0] || sd_v[0]) busy++;
    end
    checks++;
    if (nstrobe !== 0 || busy !== 0) begin
      failures++; $display("FAIL disabled_idle actual=%0d/%0d required=0/0", nstrobe, busy);
    end
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      n++;
      if (st_v[0]) break;
    end
    checks++;
    if (n !== 4 || !st_v[0]) begin
      failures++; $display("FAIL reenable_strobe actual=%0d required=4", n);
    end
    collect(0, d, lr, ok);
    checks++;
    if (d !== 64'h0000_0000_FFFF_FFFF) begin
      failures++; $display("FAIL reenable_frame actual=%h required=00000000ffffffff", d);
    end
  endtask

  task automatic test_min_divider();
    logic [63:0] d, lr;
    bit          ok;
    logic        prev;
    int          n, bad;
    left_s = 32'hA5A5_0F0F;
    right_s = 32'h8000_0001;
    do_reset();
    wait_strobe(2, 300, ok);
    prev = bclk_v[2];
    n = 0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      n++;
      if (bclk_v[2] == prev) bad++;
      prev = bclk_v[2];
      if (st_v[2]) break;
    end
    checks++;
    if (n !== 128) begin failures++; $display("FAIL div1_strobe_period actual=%0d required=128", n); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL div1_bclk_toggle actual=%0d required=0", bad); end
    collect(2, d, lr, ok);
    checks++;
    if (d !== 64'hA5A5_0F0F_8000_0001) begin
      failures++; $display("FAIL div1_frame actual=%h required=a5a50f0f80000001", d);
    end
    checks++;
    if (lr !== 64'h0000_0001_FFFF_FFFE) begin
      failures++; $display("FAIL div1_lrclk actual=%h required=00000001fffffffe", lr);
    end
  endtask

  initial begin
    test_reset();
    test_serial_frame();
    test_masking();
    test_capture_isolation();
    test_enable_midframe();
    test_min_divider();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sublime_i2s_tx.md
Name: sublime_i2s_tx

Overview:
- Serialises the synthesizer's stereo output (left_sample/right_sample, 32-bit each) into a standard I2S stream for an external audio DAC.
- Downstream consumer of the sublime top level's sample outputs; generates BCLK/LRCLK as bus master from the system clock.
- Captures one stereo frame per I2S frame and pulses sample_strobe so upstream logic can align sample production to the DAC frame rate.

Parameters:
- CLK_DIV, 8, clk cycles per BCLK half-period (>=1); fs = f_clk / (128*CLK_DIV).
- DATA_BITS, 24, significant MSBs transmitted per 32-bit slot (1..32); lower bits are sent as 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run control; low = idle outputs, counters held in reset state.
- left_sample  in  32  left-channel sample, two's complement.
- right_sample  in  32  right-channel sample, two's complement.
- sample_strobe  out  1  one-clk pulse on the cycle both samples are captured.
- i2s_bclk  out  1  bit clock, registered.
- i2s_lrclk  out  1  word select (0 = left, 1 = right), registered.
- i2s_sdata  out  1  serial data, MSB first, registered.

Behaviour:
- Reset (rst=1 at a clk edge): div_cnt=0, slot=63, shift_reg=0; i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, sample_strobe=0. rst overrides enable.
- enable=0: same state as reset, applied synchronously. Mid-frame deassertion truncates the frame with no completion. Re-enabling restarts a fresh frame.
- Divider: with enable=1, div_cnt counts 0..CLK_DIV-1. On the cycle div_cnt==CLK_DIV-1 it wraps to 0 and i2s_bclk toggles.
  - 0->1 is a rising edge: no data change.
  - 1->0 is a falling edge: advance slot.
- Slot counter: 6-bit, 0..63, increments on each falling edge and wraps 63->0.
- Load on the falling edge entering slot 0:
  - shift_reg(64) <= {mask(left_sample), mask(right_sample)}, where mask() zeroes bits [31-DATA_BITS:0]; for DATA_BITS=32 there is no masking.
  - sample_strobe=1 for exactly that clk cycle; 0 otherwise.
- On falling edges into slots 1..63: shift_reg <= shift_reg<<1.
- i2s_sdata = shift_reg[63], updated in the same cycle as the bclk falling edge, so data is stable for the DAC across the rising edge.
- i2s_lrclk = ((slot+1) mod 64) >= 32, updated with slot on the falling edge.
  - Goes high entering slot 31 and low entering slot 63.
  - Gives the standard I2S one-bit lead: left MSB in slot 0, right MSB in slot 32.
- Timing from reset release with enable=1:
  - First bclk rise at cycle CLK_DIV.
  - First load/strobe at cycle 2*CLK_DIV.
  - Strobe period is 128*CLK_DIV cycles.
- Sample inputs are sampled only on the load cycle. Changes at any other time do not affect the frame in flight.
- CLK_DIV=1 is legal: bclk = clk/2.

Decomposition:
- sublime_pkg:
  - SLOT_BITS=32, FRAME_BITS=64, SLOT_CNT_W=6.
  - function i2s_mask(sample, DATA_BITS).
- One natural sub-module: sublime_i2s_bclk_gen (div_cnt, i2s_bclk, rise/fall one-cycle enables). The remainder (slot counter, shift register, lrclk, strobe) stays in sublime_i2s_tx.

Test Plan:
- Reset timing: CLK_DIV=2, rst for 3 cycles, enable=1 -> outputs 0 during reset; bclk rises at cycle 2, falls at cycle 4; sample_strobe pulses at cycle 4; next strobe at cycle 260.
- Serial frame: DATA_BITS=32, L=0xA5A5_0F0F, R=0x8000_0001 -> sampling sdata on bclk rising edges recovers L over slots 0-31 and R over 32-63, MSB first. lrclk is 0 during slots 63 and 0-30 and 1 during slots 31-62.
- Masking: DATA_BITS=24, L=R=0xFFFF_FFFF -> each slot carries 24 ones then 8 zeros.
- Capture isolation: change L from 0x1234_5678 to 0xDEAD_BEEF one cycle after the strobe -> the current frame sends 0x1234_5678; the next frame sends 0xDEAD_BEEF.
- Enable mid-frame: drop enable in slot 40 -> next cycle bclk=lrclk=sdata=0 and no strobe. Re-raise it -> strobe 2*CLK_DIV cycles later with a full frame.
- Minimum divider: CLK_DIV=1 -> bclk toggles every clk cycle, strobe period is 128 cycles, data correct as in the serial-frame scenario.
